// File: rtl/ramp_decoder_if.sv
// Sample bus between the ramp generator side and ramp_decoder.
// Carries the optional stale flag when RAMP_DECODER_TIMEOUT_EN is set.
interface ramp_decoder_if #(
  parameter int W     = 16,
  parameter int RUN_W = 16,
  parameter int ERR_W = 8
);
  logic             sample_en;
  logic [W-1:0]     data;
  logic             valid;
  logic [W-1:0]     delta;
  logic             dir;
  logic [2:0]       tier;
  logic [RUN_W-1:0] run_len;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
`ifdef RAMP_DECODER_TIMEOUT_EN
  logic             stale;
`endif

  modport master (
    output sample_en, data,
    input  valid, delta, dir, tier,
    input  run_len, err, err_cnt
`ifdef RAMP_DECODER_TIMEOUT_EN
    , input stale
`endif
  );

  modport slave (
    input  sample_en, data,
    output valid, delta, dir, tier,
    output run_len, err, err_cnt
`ifdef RAMP_DECODER_TIMEOUT_EN
    , output stale
`endif
  );
endinterface

// File: rtl/ramp_decoder.sv
// Ramp test-stream decoder: recovers direction, step tier, run length, errors.
// Optional stale timeout enabled by RAMP_DECODER_TIMEOUT_EN.
module ramp_decoder #(
  parameter int W       = 16,
  parameter int STEP1   = 1,
  parameter int STEP2   = 7,
  parameter int STEP3   = 31,
  parameter int STEP4   = 65,
  parameter int RUN_W   = 16,
  parameter int ERR_W   = 8,
  parameter int TIMEOUT = 4194304
) (
  input logic           clk,
  input logic           reset,
  ramp_decoder_if.slave bus
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] RAMP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     delta_q, delta_d;
  logic             dir_q, dir_d;
  logic [2:0]       tier_q, tier_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] ecnt_q, ecnt_d;

  logic [W-1:0] d, m;
  logic [2:0]   tc;
  logic         step, bad;

  always_comb begin
    d = bus.data - prev_q;
    m = d[W-1] ? (W'(0) - d) : d;
    if (d == '0)                tc = 3'd0;
    else if (m == W'(STEP1))    tc = 3'd1;
    else if (m == W'(STEP2))    tc = 3'd2;
    else if (m == W'(STEP3))    tc = 3'd3;
    else if (m == W'(STEP4))    tc = 3'd4;
    else if (bus.data == '0)    tc = 3'd6;
    else                        tc = 3'd7;
    step = (tc >= 3'd1) && (tc <= 3'd4);
  end

`ifdef RAMP_DECODER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stale_q, stale_d;
`endif

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    valid_d = 1'b0;
    delta_d = delta_q;
    dir_d   = dir_q;
    tier_d  = tier_q;
    run_d   = run_q;
    err_d   = err_q;
    ecnt_d  = ecnt_q;
    bad     = 1'b0;
`ifdef RAMP_DECODER_TIMEOUT_EN
    cnt_d   = cnt_q;
    stale_d = stale_q;
`endif
    if (bus.sample_en) begin
      prev_d = bus.data;
`ifdef RAMP_DECODER_TIMEOUT_EN
      cnt_d   = '0;
      stale_d = 1'b0;
`endif
      if (state_q == EMPTY) begin
        state_d = HOLD;
      end else begin
        valid_d = 1'b1;
        delta_d = d;
        tier_d  = tc;
        if (step) begin
          dir_d   = ~d[W-1];
          state_d = RAMP;
          // in a ramp, direction must hold and tier may only climb
          bad = (state_q == RAMP) &&
                ((dir_d != dir_q) || (tc < tier_q));
        end else begin
          state_d = HOLD;
          bad     = (tc == 3'd7);
        end
        if ({dir_d, tier_d} != {dir_q, tier_q})
          run_d = RUN_W'(1);
        else if (run_q != '1)
          run_d = run_q + RUN_W'(1);
        if (bad) begin
          err_d = 1'b1;
          if (ecnt_q != '1)
            ecnt_d = ecnt_q + ERR_W'(1);
        end
      end
    end
`ifdef RAMP_DECODER_TIMEOUT_EN
    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
      cnt_d   = cnt_q + CNT_W'(1);
      stale_d = 1'b1;
      state_d = EMPTY;
      run_d   = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      prev_q  <= '0;
      valid_q <= 1'b0;
      delta_q <= '0;
      dir_q   <= 1'b0;
      tier_q  <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      delta_q <= delta_d;
      dir_q   <= dir_d;
      tier_q  <= tier_d;
      run_q   <= run_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

`ifdef RAMP_DECODER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  assign bus.stale = stale_q;
`endif

  assign bus.valid   = valid_q;
  assign bus.delta   = delta_q;
  assign bus.dir     = dir_q;
  assign bus.tier    = tier_q;
  assign bus.run_len = run_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = ecnt_q;
endmodule
